// File: rtl/prio_enc_pend.sv
// rtl/prio_enc_pend.sv - sticky-pending priority encoder with registered valid/ready index slot
//
// Optional feature macro: PENC_MASK_EN (adds the mask input; default build has no mask)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset, clears all state
//   enable     in   0 = ignore req; pending and output slot keep operating
//   clear      in   synchronous flush of pending and slot, dominates all other inputs
//   req        in   [N-1:0] request pulses, sampled at every edge with enable=1
//   mask       in   [N-1:0] (PENC_MASK_EN only) 1 = exclude bit from selection
//   out_valid  out  slot holds a request
//   out_idx    out  [IDX_W-1:0] index of the request in the slot
//   out_ready  in   consumer accepts the slot when out_valid && out_ready
//   pending    out  [N-1:0] pending requests, excluding the one in the slot
//   dropped    out  one-cycle pulse: a req bit arrived while already pending
module prio_enc_pend #(
    parameter int N        = 8,
    parameter int LSB_HIGH = 1,
    localparam int IDX_W   = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             clear,
    input  logic [N-1:0]     req,
`ifdef PENC_MASK_EN
    input  logic [N-1:0]     mask,
`endif
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    input  logic             out_ready,
    output logic [N-1:0]     pending,
    output logic             dropped
);

    logic [N-1:0]     elig;
    logic [N-1:0]     req_en;
    logic [N-1:0]     moved;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_hit;
    logic             load;

`ifdef PENC_MASK_EN
    // Masked bits keep capturing; they only sit out of selection.
    assign elig = pending & ~mask;
`else
    assign elig = pending;
`endif

    assign req_en = req & {N{enable}};
    assign load   = !out_valid || out_ready;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        sel_idx = '0;
        if (LSB_HIGH != 0) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (elig[i]) sel_idx = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (elig[i]) sel_idx = IDX_W'(i);
            end
        end
    end

    assign sel_hit = |elig;

    // One-hot of the bit leaving pending for the slot this edge.
    always_comb begin
        moved = '0;
        if (load && sel_hit) moved[sel_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            dropped   <= 1'b0;
        end else if (clear) begin
            pending   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            dropped   <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= sel_hit;
                out_idx   <= sel_idx;
            end
            // A new req on the bit being moved re-pends it (set wins).
            pending <= (pending & ~moved) | req_en;
            dropped <= |(req_en & pending & ~moved);
        end
    end

endmodule

// File: tb/tb_prio_enc_pend.sv
// tb/tb_prio_enc_pend.sv - directed self-checking bench for prio_enc_pend
module tb_prio_enc_pend;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       clear;
    logic [7:0] req;
`ifdef PENC_MASK_EN
    logic [7:0] mask;
`endif
    logic       out_valid;
    logic [2:0] out_idx;
    logic       out_ready;
    logic [7:0] pending;
    logic       dropped;

    int total = 0;
    int bad   = 0;

    prio_enc_pend #(.N(8), .LSB_HIGH(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .clear     (clear),
        .req       (req),
`ifdef PENC_MASK_EN
        .mask      (mask),
`endif
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_ready (out_ready),
        .pending   (pending),
        .dropped   (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] v, input logic [31:0] idx,
                           input logic [31:0] pnd, input logic [31:0] drp);
        chk({tag, ".valid"},   32'(out_valid), v);
        chk({tag, ".idx"},     32'(out_idx),   idx);
        chk({tag, ".pending"}, 32'(pending),   pnd);
        chk({tag, ".dropped"}, 32'(dropped),   drp);
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        clear     = 1'b0;
        req       = 8'h00;
        out_ready = 1'b0;
`ifdef PENC_MASK_EN
        mask      = 8'h00;
`endif
        #12;
        chk_all("reset", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_all("idle", 0, 0, 0, 0);
        end

        // Priority + drain
        req = 8'hA4; out_ready = 1'b1;
        @(negedge clk); req = 8'h00;
        chk_all("capture", 0, 0, 'hA4, 0);
        @(negedge clk); chk_all("drain0", 1, 2, 'hA0, 0);
        @(negedge clk); chk_all("drain1", 1, 5, 'h80, 0);
        @(negedge clk); chk_all("drain2", 1, 7, 0, 0);
        @(negedge clk); chk_all("drained", 0, 0, 0, 0);

        // Stall/hold
        req = 8'h40; out_ready = 1'b0;
        @(negedge clk); req = 8'h00;
        @(negedge clk); chk_all("stall_load", 1, 6, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk_all("stall_hold", 1, 6, 0, 0);
        end
        req = 8'h02;
        @(negedge clk); req = 8'h00;
        chk_all("no_preempt", 1, 6, 'h02, 0);
        out_ready = 1'b1;
        @(negedge clk); chk_all("after_stall", 1, 1, 0, 0);
        @(negedge clk); chk_all("stall_empty", 0, 0, 0, 0);

        // Duplicate
        req = 8'h09; out_ready = 1'b0;
        @(negedge clk); req = 8'h00;
        chk_all("dup_cap", 0, 0, 'h09, 0);
        @(negedge clk); chk_all("dup_slot", 1, 0, 'h08, 0);
        req = 8'h08;
        @(negedge clk); req = 8'h00;
        chk_all("dup_hit", 1, 0, 'h08, 1);
        @(negedge clk); chk_all("dup_once", 1, 0, 'h08, 0);

        // Set wins on the bit being moved
        req = 8'h08; out_ready = 1'b1;
        @(negedge clk); req = 8'h00;
        chk_all("setwins", 1, 3, 'h08, 0);
        @(negedge clk); chk_all("setwins_again", 1, 3, 0, 0);
        @(negedge clk); chk_all("setwins_empty", 0, 0, 0, 0);

        // enable=0 ignores req but still drains
        req = 8'h30; out_ready = 1'b0;
        @(negedge clk); req = 8'h00;
        @(negedge clk); chk_all("en_slot", 1, 4, 'h20, 0);
        enable = 1'b0; req = 8'hFF;
        @(negedge clk); chk_all("en_off", 1, 4, 'h20, 0);
        out_ready = 1'b1;
        @(negedge clk); chk_all("en_off_drain", 1, 5, 0, 0);
        @(negedge clk); chk_all("en_off_empty", 0, 0, 0, 0);
        enable = 1'b1; req = 8'h00;

        // clear dominates
        req = 8'h01; out_ready = 1'b0;
        @(negedge clk); req = 8'h06;
        @(negedge clk); req = 8'h00;
        chk_all("pre_clear", 1, 0, 'h06, 0);
        clear = 1'b1; req = 8'h01;
        @(negedge clk); clear = 1'b0; req = 8'h00;
        chk_all("clear", 0, 0, 0, 0);
        @(negedge clk); chk_all("post_clear", 0, 0, 0, 0);

        // Async reset mid-drain
        req = 8'h0F; out_ready = 1'b1;
        @(negedge clk); req = 8'h00;
        @(negedge clk); chk_all("pre_rst", 1, 0, 'h0E, 0);
        #2 rst = 1'b1;
        #1 chk_all("async_rst", 0, 0, 0, 0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); chk_all("post_rst", 0, 0, 0, 0);

`ifdef PENC_MASK_EN
        req = 8'h03; mask = 8'h01; out_ready = 1'b0;
        @(negedge clk); req = 8'h00;
        @(negedge clk); chk_all("mask_sel", 1, 1, 'h01, 0);
        mask = 8'h00; out_ready = 1'b1;
        @(negedge clk); chk_all("unmask_sel", 1, 0, 0, 0);
        @(negedge clk); chk_all("mask_empty", 0, 0, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prio_enc_pend.md
Name: prio_enc_pend

Overview:
- Parametrised, registered successor to the team's combinational 8-to-3 priority encoder.
- Captures request pulses from N sources into a sticky pending register.
- Presents the highest-priority pending index on a valid/ready output slot and retires each request once it is accepted.
- Sits between interrupt/event sources and a single consumer, such as a controller FSM or CSR block.

Parameters:
- N, 8: number of request channels; N >= 2.
- IDX_W, $clog2(N): output index width; derived, not overridden.
- LSB_HIGH, 1: 1 = bit 0 has highest priority; 0 = bit N-1 has highest priority.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high. Clears all state.
- enable  in  1  when 0, req is ignored. Pending bits and the output slot keep operating.
- clear  in  1  synchronous flush of pending and output slot; dominates all other inputs.
- req  in  N  request pulses; bit i is sampled at every edge where enable=1.
- out_valid  out  1  output slot holds a request.
- out_idx  out  IDX_W  binary index of the request in the slot.
- out_ready  in  1  consumer accepts the slot when out_valid && out_ready at an edge.
- pending  out  N  pending vector, excluding the request in the slot.
- dropped  out  1  one-cycle pulse: a req bit arrived while the same bit was already pending.

Behaviour:
- Reset (rst=1, async): pending=0, out_valid=0, out_idx=0, dropped=0.
- clear=1 at an edge:
  - pending<=0, out_valid<=0, out_idx<=0, dropped<=0.
  - req in the same cycle is discarded.
- Eligible vector: elig = pending (ANDed with ~mask when PENC_MASK_EN).
- Slot load condition: load = !out_valid || out_ready.
- On an edge with load=1:
  - out_valid <= |elig.
  - out_idx <= index of the highest-priority set bit of elig per LSB_HIGH, or 0 if elig=0.
  - The selected bit is removed from pending at the same edge.
- On an edge with load=0: out_valid and out_idx hold, stable while stalled.
- Pending update: pending <= (pending & ~moved) | (req & {N{enable}}).
  - moved = one-hot of the bit loaded into the slot this edge.
  - Set wins: a req on a bit being moved this edge re-pends it.
- dropped <= |(req & {N{enable}} & pending & ~moved). A merged duplicate is counted once; no queueing.
- Latency: req sampled at edge k with an empty slot -> out_valid=1 after edge k+1.
- Throughput: one accept per cycle while out_ready=1.
- Priority is re-evaluated only on load. A higher-priority arrival does not pre-empt a stalled slot.
- The request in the slot is not visible in pending.
- enable=0 does not block draining of already-pending requests.
- Reset asserted mid-stall or mid-drain: all state lost immediately; no pending request survives.
- No combinational path from req to any output; all outputs are registered.

Optional Feature:
- Macro: PENC_MASK_EN.
- Defined:
  - Adds input port mask (N bits); mask[i]=1 excludes bit i from selection.
  - Masked bits still capture and stay pending. They become eligible on the first load edge after unmask.
  - A request already in the slot is unaffected by later masking.
- Undefined:
  - No mask port; elig = pending.

Test Plan:
- Reset/idle: N=8, LSB_HIGH=1. Release rst with req=0 -> out_valid=0, out_idx=0, pending=0, dropped=0 for 5 cycles.
- Priority + drain: req=8'b1010_0100 for one cycle, out_ready=1.
  - out_idx sequence 2, 5, 7 on consecutive cycles, starting 2 edges after the req edge.
  - out_valid then drops; pending goes 8'b1010_0000 -> 8'b1000_0000 -> 0.
- Stall/hold: pend bit 6, out_ready=0 for 4 cycles, then pulse req bit 1.
  - out_idx stays 6.
  - On the next accept, out_idx=1.
- Duplicate/set-wins:
  - Req bit 3 twice while pending -> dropped=1 for exactly one cycle.
  - Req bit 3 on the same edge it is moved to the slot -> pending[3]=1 afterwards, dropped=0.
- clear/enable:
  - enable=0 with req=8'hFF -> pending unchanged.
  - clear=1 together with req=8'h01 while out_valid=1 -> out_valid=0, pending=0 next cycle.
  - Async rst mid-drain -> outputs zero without a clock edge.
- PENC_MASK_EN: pending=8'b0000_0011, mask=8'b0000_0001 -> out_idx=1. Clear the mask -> next out_idx=0.
